// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed 4-digit active-low 7-segment bus.
// Debounces each digit dwell, decodes glyphs and rebuilds the EW/SN countdown values.
module seg_scan_decoder #(
  parameter int STABLE_CYC = 3,
  parameter int BLANK_CYC  = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] sel,
  input  logic [7:0] seg_led,
  output logic [5:0] ew_time,
  output logic [5:0] sn_time,
  output logic       time_valid,
  output logic       frame_err,
  output logic       blank
);

  typedef enum logic [1:0] {SYNC = 2'd0, D1 = 2'd1, D2 = 2'd2, D3 = 2'd3} state_t;

  localparam logic [7:0] STAB_TGT  = 8'(STABLE_CYC - 1);
  localparam logic [7:0] BLANK_TGT = 8'(BLANK_CYC);

  // Decimal point carries no digit information.
  logic unused_dp;
  assign unused_dp = seg_led[7];

  logic [3:0] s_sel, p_sel;
  logic [6:0] s_seg, p_seg;
  logic [7:0] stab_cnt, idle_cnt;
  state_t     state;
  logic [3:0] d0, d1, d2, d3;
  logic       cmp_pend;

  logic       sel_onehot, sel_idle, sel_bad;
  logic [1:0] pos, exp_pos;
  logic [7:0] stab_next, idle_next;
  logic       accept, bad_evt, blank_evt, acc_err;
  logic       glyph_ok;
  logic [3:0] glyph_val;
  logic [6:0] e_sum, s_sum;
  logic       overflow, tv_next, fe_next;

  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    case ({1'b1, seg})
      8'hC0:   return 5'h10;
      8'hF9:   return 5'h11;
      8'hA4:   return 5'h12;
      8'hB0:   return 5'h13;
      8'h99:   return 5'h14;
      8'h92:   return 5'h15;
      8'h82:   return 5'h16;
      8'hF8:   return 5'h17;
      8'h80:   return 5'h18;
      8'h90:   return 5'h19;
      default: return 5'h00;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_onehot = 1'b1;
    pos        = 2'd0;
    case (s_sel)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: sel_onehot = 1'b0;
    endcase
    sel_idle = (s_sel == 4'hF);
    sel_bad  = !sel_onehot && !sel_idle;

    if ({s_sel, s_seg} != {p_sel, p_seg}) stab_next = 8'd0;
    else if (stab_cnt == 8'hFF)           stab_next = 8'hFF;
    else                                  stab_next = stab_cnt + 8'd1;

    if (!sel_idle)              idle_next = 8'd0;
    else if (idle_cnt == 8'hFF) idle_next = 8'hFF;
    else                        idle_next = idle_cnt + 8'd1;

    // The dwell target is hit exactly once because the counter saturates above it.
    accept    = sel_onehot && (stab_next == STAB_TGT);
    bad_evt   = sel_bad    && (stab_next == STAB_TGT);
    blank_evt = sel_idle   && (idle_next == BLANK_TGT);

    {glyph_ok, glyph_val} = decode_glyph(s_seg);
    exp_pos = state;
    acc_err = accept && (!glyph_ok || (pos != exp_pos));

    e_sum    = 7'({d0, 3'b000}) + 7'({d0, 1'b0}) + 7'(d1);
    s_sum    = 7'({d2, 3'b000}) + 7'({d2, 1'b0}) + 7'(d3);
    overflow = (e_sum > 7'd63) || (s_sum > 7'd63);

    // A clean completion suppresses any error raised in the same cycle.
    tv_next = cmp_pend && !overflow;
    fe_next = !tv_next && ((cmp_pend && overflow) || acc_err || bad_evt);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s_sel      <= 4'hF;
      p_sel      <= 4'hF;
      s_seg      <= 7'h7F;
      p_seg      <= 7'h7F;
      stab_cnt   <= 8'd0;
      idle_cnt   <= 8'd0;
      state      <= SYNC;
      d0         <= 4'd0;
      d1         <= 4'd0;
      d2         <= 4'd0;
      d3         <= 4'd0;
      cmp_pend   <= 1'b0;
      ew_time    <= 6'd0;
      sn_time    <= 6'd0;
      time_valid <= 1'b0;
      frame_err  <= 1'b0;
      blank      <= 1'b1;
    end else begin
      s_sel      <= sel;
      s_seg      <= seg_led[6:0];
      p_sel      <= s_sel;
      p_seg      <= s_seg;
      stab_cnt   <= stab_next;
      idle_cnt   <= idle_next;
      cmp_pend   <= 1'b0;
      time_valid <= tv_next;
      frame_err  <= fe_next;

      if (tv_next) begin
        ew_time <= e_sum[5:0];
        sn_time <= s_sum[5:0];
      end

      if (accept) begin
        if (glyph_ok) blank <= 1'b0;
        if (!glyph_ok) begin
          state <= SYNC;
        end else if (pos == 2'd0) begin
          // A d0 always opens a new frame, even when it arrives out of order.
          d0    <= glyph_val;
          state <= D1;
        end else if (pos == exp_pos) begin
          case (state)
            D1: begin d1 <= glyph_val; state <= D2; end
            D2: begin d2 <= glyph_val; state <= D3; end
            D3: begin d3 <= glyph_val; state <= SYNC; cmp_pend <= 1'b1; end
            default: state <= SYNC;
          endcase
        end else begin
          state <= SYNC;
        end
      end else if (bad_evt) begin
        state <= SYNC;
      end else if (blank_evt) begin
        blank <= 1'b1;
        state <= SYNC;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: table-driven frames plus hand sequences,
// with a scoreboard of expected time_valid/frame_err pulses.
module tb_seg_scan_decoder;

  localparam int DWELL = 5;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [3:0] sel;
  logic [7:0] seg_led;
  logic [5:0] ew_time, sn_time;
  logic       time_valid, frame_err, blank;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       is_err;
    logic [5:0] ew;
    logic [5:0] sn;
  } exp_t;

  typedef struct {
    int d0, d1, d2, d3;
    bit dp;
    bit is_err;
    int ew, sn;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[7];

  logic [7:0] glyph [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg_scan_decoder #(.STABLE_CYC(3), .BLANK_CYC(8)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .sel        (sel),
    .seg_led    (seg_led),
    .ew_time    (ew_time),
    .sn_time    (sn_time),
    .time_valid (time_valid),
    .frame_err  (frame_err),
    .blank      (blank)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every output pulse must match the oldest expectation.
  always @(negedge sys_clk) begin
    if (!sys_rst && (time_valid || frame_err)) begin
      if (time_valid && frame_err) check("pulse_exclusive", 1, 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {time_valid, frame_err}, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind_err", frame_err, mon_e.is_err);
        if (time_valid) begin
          check("pulse_ew_time", ew_time, mon_e.ew);
          check("pulse_sn_time", sn_time, mon_e.sn);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic show(input int pos, input logic [7:0] seg, input int dwell);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << pos;
    sel     = ~one_hot;
    seg_led = seg;
    repeat (dwell) @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    sel     = 4'hF;
    seg_led = 8'hFF;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push_err();
    exp_t e;
    e = '{1'b1, 6'd0, 6'd0};
    sb.push_back(e);
  endtask

  // Reference model for a complete frame result.
  task automatic push_frame(input int a, input int b, input int c, input int d);
    exp_t e;
    int ev, sv;
    ev = a * 10 + b;
    sv = c * 10 + d;
    e.is_err = (ev > 63) || (sv > 63);
    e.ew     = 6'(ev);
    e.sn     = 6'(sv);
    sb.push_back(e);
  endtask

  task automatic send_digits(input int a, input int b, input int c, input int d, input bit dp);
    logic [7:0] mask;
    mask = dp ? 8'h7F : 8'hFF;
    show(0, glyph[a] & mask, DWELL);
    show(1, glyph[b] & mask, DWELL);
    show(2, glyph[c] & mask, DWELL);
    show(3, glyph[d] & mask, DWELL);
  endtask

  task automatic frame(input int a, input int b, input int c, input int d);
    push_frame(a, b, c, d);
    send_digits(a, b, c, d, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    @(negedge sys_clk);
    check(name, sb.size(), 0);
  endtask

  initial begin
    vecs[0] = '{2, 5, 0, 7, 1'b0, 1'b0, 25,  7};
    vecs[1] = '{6, 3, 6, 3, 1'b1, 1'b0, 63, 63};
    vecs[2] = '{7, 0, 0, 5, 1'b0, 1'b1, 63, 63};
    vecs[3] = '{0, 9, 6, 4, 1'b0, 1'b1, 63, 63};
    vecs[4] = '{0, 0, 0, 0, 1'b1, 1'b0,  0,  0};
    vecs[5] = '{5, 9, 4, 8, 1'b0, 1'b0, 59, 48};
    vecs[6] = '{6, 4, 0, 0, 1'b0, 1'b1, 59, 48};

    sys_rst = 1'b1;
    sel     = 4'hF;
    seg_led = 8'hFF;
    #12;
    check("reset_ew", ew_time, 0);
    check("reset_sn", sn_time, 0);
    check("reset_blank", blank, 1);
    check("reset_tv", time_valid, 0);
    check("reset_fe", frame_err, 0);
    #11 sys_rst = 1'b0;
    @(negedge sys_clk);

    // Table-driven frames: valid values, the 63 boundary and >63 overflows.
    for (int i = 0; i < 7; i++) begin
      exp_t e;
      e = '{vecs[i].is_err, 6'(vecs[i].ew), 6'(vecs[i].sn)};
      sb.push_back(e);
      send_digits(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].dp);
      wait_drain($sformatf("vec%0d_drain", i));
      check($sformatf("vec%0d_ew", i), ew_time, vecs[i].ew);
      check($sformatf("vec%0d_sn", i), sn_time, vecs[i].sn);
      check($sformatf("vec%0d_blank", i), blank, 0);
    end

    // Invalid glyph at position 1, then a clean frame.
    push_err();
    show(0, glyph[1], DWELL);
    show(1, 8'hFF, DWELL);
    wait_drain("badglyph_drain");
    check("badglyph_ew_hold", ew_time, 59);
    check("badglyph_sn_hold", sn_time, 48);
    frame(1, 2, 3, 4);
    wait_drain("after_badglyph_drain");
    check("after_badglyph_ew", ew_time, 12);

    // Order d0,d2 is an error; a full frame then completes.
    push_err();
    show(0, glyph[4], DWELL);
    show(2, glyph[5], DWELL);
    wait_drain("order_drain");
    frame(4, 5, 1, 6);
    wait_drain("after_order_drain");
    check("after_order_sn", sn_time, 16);

    // d0 repeated mid-frame restarts the frame from the new d0.
    push_err();
    show(0, glyph[3], DWELL);
    show(1, glyph[3], DWELL);
    frame(2, 1, 3, 3);
    wait_drain("restart_drain");
    check("restart_ew", ew_time, 21);

    // Illegal sel pattern held stable.
    push_err();
    show(0, glyph[1], DWELL);
    sel = 4'b1100; seg_led = glyph[0];
    repeat (DWELL) @(negedge sys_clk);
    frame(3, 0, 2, 9);
    wait_drain("badsel_drain");
    check("badsel_sn", sn_time, 29);

    // Blank timeout mid-frame drops the partial frame silently.
    show(0, glyph[1], DWELL);
    show(1, glyph[1], DWELL);
    idle(10);
    check("blank_set", blank, 1);
    check("blank_no_pulse", sb.size(), 0);
    check("blank_ew_hold", ew_time, 30);
    show(0, glyph[3], DWELL);
    check("blank_clear", blank, 0);
    push_frame(3, 1, 2, 2);
    show(1, glyph[1], DWELL);
    show(2, glyph[2], DWELL);
    show(3, glyph[2], DWELL);
    wait_drain("after_blank_drain");
    check("after_blank_ew", ew_time, 31);

    // A 7-sample idle gap is tolerated and the frame resumes.
    push_frame(4, 2, 1, 0);
    show(0, glyph[4], DWELL);
    show(1, glyph[2], DWELL);
    idle(7);
    check("short_idle_blank", blank, 0);
    show(2, glyph[1], DWELL);
    show(3, glyph[0], DWELL);
    wait_drain("short_idle_drain");
    check("short_idle_ew", ew_time, 42);
    check("short_idle_sn", sn_time, 10);

    // Asynchronous reset while the FSM waits for d2.
    show(0, glyph[2], DWELL);
    show(1, glyph[2], 2);
    #2 sys_rst = 1'b1;
    sel = 4'hF; seg_led = 8'hFF;
    #1;
    check("midreset_ew", ew_time, 0);
    check("midreset_sn", sn_time, 0);
    check("midreset_blank", blank, 1);
    repeat (2) @(negedge sys_clk);
    #3 sys_rst = 1'b0;
    @(negedge sys_clk);
    idle(3);
    check("post_reset_no_pulse", sb.size(), 0);
    frame(2, 2, 3, 3);
    wait_drain("post_reset_drain");
    check("post_reset_ew", ew_time, 22);
    check("post_reset_sn", sn_time, 33);

    idle(12);
    check("final_queue_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
